raster_pixel_streamer: RTL and testbench
========================================

Name: raster_pixel_streamer

Overview:
- Transmit side of the pixel stream consumed by the window line buffers. After a start pulse, reads one IMG_W x IMG_H frame from a synchronous-read frame memory in raster order.
- Emits one pixel per transfer on a valid/ready stream with sof/eol markers.
- Inserts optional horizontal blanking between lines.
- Feeds the Canny front end (line buffer, then Sobel and NMS) from frame RAM or from a bench model.

Parameters:
IMG_W, 256, pixels per line (>=4)
IMG_H, 256, lines per frame (>=3)
W, 8, pixel width in bits
HBLANK, 0, idle read cycles inserted after each line except the last (0..255)
ADDR_W, $clog2(IMG_W*IMG_H), memory address width (derived)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin a frame; ignored while busy=1
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  read address, row*IMG_W+col
mem_rdata  in  W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  pixel available
out_ready  in  1  downstream accepts pixel
out_pixel  out  W  pixel data
out_sof  out  1  high with pixel (0,0)
out_eol  out  1  high with pixel col IMG_W-1 of every row
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse, registered, the cycle after the final pixel transfer

Behaviour:
- Reset: mem_rd_en, out_valid, out_sof, out_eol, busy and done are 0; mem_addr and out_pixel are 0. FSM is IDLE, counters are 0, the buffer is empty and no read is in flight. Reset asserted mid-frame aborts immediately. There is no partial-frame resume.
- Transfer: occurs on a clock edge when out_valid and out_ready are both 1. out_pixel, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.
- Output stage: a 2-entry FIFO (pixel plus sof/eol tags).
  - A read may issue only if FIFO occupancy plus reads in flight is less than 2, counting a same-cycle pop as freeing a slot.
  - No pixel is ever dropped or duplicated under any out_ready pattern.
- FSM states:
  - IDLE: busy=0. Leaves on start=1, sets busy, clears row/col, goes to STREAM.
  - STREAM: issues a read (mem_rd_en=1, mem_addr=current) when the credit rule allows, then advances col. When col=IMG_W-1 is issued, col wraps to 0 and row increments. Goes to HBLANK if HBLANK>0 and the row was not IMG_H-1. Goes to DRAIN if the row was IMG_H-1.
  - HBLANK: no reads for exactly HBLANK cycles, then back to STREAM.
  - DRAIN: waits until the FIFO is empty and no read is in flight. Pulses done, clears busy, goes to IDLE.
- Address generation: by increment, with no multiplier. mem_addr wraps only through frame restart.
- Latency with out_ready held at 1:
  - start sampled at edge N; first mem_rd_en at cycle N+1; first out_valid at cycle N+3.
  - Throughput is 1 pixel per clock.
  - Frame time from start to done is IMG_W*IMG_H + (IMG_H-1)*HBLANK + 3 cycles.
- Simultaneous events: start coinciding with done goes to IDLE and is ignored. A start during busy is dropped and not queued.

Optional Feature:
TEST_PATTERN_EN
- Defined: an input tp_sel (1 bit, sampled only on start acceptance) is added.
  - tp_sel=1: pixel = (col + row) truncated to W bits. No memory reads are issued (mem_rd_en stays 0), but timing, sof/eol, HBLANK and done are identical.
  - tp_sel=0: normal memory operation.
- Not defined: the port and logic are absent, and behaviour is memory only.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=3, HBLANK=0, memory holds addr+0x10, out_ready=1.
  - Expect 12 pixels 0x10..0x1B.
  - out_sof only on the first pixel; out_eol on pixels 4, 8 and 12.
  - out_valid at N+3; done at N+15.
- Backpressure: out_ready random at 50% plus a 20-cycle hold low mid-row.
  - Pixel sequence is identical to the basic frame, with no gaps in addresses and no duplicates.
  - Outputs stay stable while stalled.
  - mem_rd_en is never asserted with FIFO plus in-flight already at 2.
- Blanking: HBLANK=5, out_ready=1.
  - out_valid is low for exactly 5 cycles between each eol and the next row's first pixel.
  - There is no gap after the last row; done at N+25.
- Start handling: a start pulse while busy is ignored.
  - A start on the same cycle as done starts no frame.
  - A start 1 cycle after done produces a second correct frame with out_sof again.
- Reset mid-frame: drop rst_n after pixel 6.
  - All outputs go to 0 asynchronously.
  - After release, a start yields a full frame from addr 0.
- TEST_PATTERN_EN with tp_sel=1, IMG_W=4, IMG_H=3.
  - Pixels are 0,1,2,3,1,2,3,4,2,3,4,5.
  - mem_rd_en stays 0 throughout.

Source files
------------

// File: rtl/raster_pixel_streamer.sv
// raster_pixel_streamer: raster-order frame reader feeding a 2-entry output FIFO.
// Define TEST_PATTERN_EN to add tp_sel and the (col+row) generated pattern.
module raster_pixel_streamer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int W      = 8,
    parameter int HBLANK = 0,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef TEST_PATTERN_EN
    input  logic              tp_sel,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_pixel,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
    localparam logic [7:0] BLANK_INIT = 8'((HBLANK > 0) ? HBLANK-1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_STREAM,
        S_HBLANK,
        S_DRAIN
    } state_t;

    state_t state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [ADDR_W-1:0] addr;
    logic [7:0] blank_cnt;

    logic pend;
    logic pend_sof;
    logic pend_eol;
    logic [W-1:0] pend_data;

    logic [1:0] occ;
    logic [1:0] occ_nxt;
    logic [1:0] wpos;
    logic [2:0] used;
    logic [W+1:0] ent0;
    logic [W+1:0] ent1;
    logic [W+1:0] nxt0;
    logic [W+1:0] nxt1;
    logic [W+1:0] push_ent;
    logic pop;
    logic push;
    logic issue;

`ifdef TEST_PATTERN_EN
    logic tp_mode;
    logic [W-1:0] pend_pix;
    logic [W-1:0] tp_pix;
    assign tp_pix = W'(col) + W'(row);
    assign pend_data = tp_mode ? pend_pix : mem_rdata;
    assign mem_rd_en = issue & ~tp_mode;
`else
    assign pend_data = mem_rdata;
    assign mem_rd_en = issue;
`endif

    assign out_valid = (occ != 2'd0);
    assign pop = out_valid & out_ready;
    assign push = pend;
    assign used = {1'b0, occ} + {2'b00, pend};
    // a pop this cycle frees a slot for the read issued now
    assign issue = (state == S_STREAM) && (used < (3'd2 + {2'b00, pop}));
    assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};
    assign wpos = occ - {1'b0, pop};
    assign push_ent = {pend_sof, pend_eol, pend_data};

    assign mem_addr = addr;
    assign out_pixel = ent0[W-1:0];
    assign out_sof = out_valid & ent0[W+1];
    assign out_eol = out_valid & ent0[W];

    always_comb begin
        nxt0 = ent0;
        nxt1 = ent1;
        if (pop) nxt0 = ent1;
        if (push) begin
            if (wpos == 2'd0) nxt0 = push_ent;
            else nxt1 = push_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            blank_cnt <= '0;
            pend      <= 1'b0;
            pend_sof  <= 1'b0;
            pend_eol  <= 1'b0;
            occ       <= 2'd0;
            ent0      <= '0;
            ent1      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TEST_PATTERN_EN
            tp_mode   <= 1'b0;
            pend_pix  <= '0;
`endif
        end else begin
            occ  <= occ_nxt;
            ent0 <= nxt0;
            ent1 <= nxt1;
            pend <= issue;
            done <= 1'b0;
            if (issue) begin
                pend_sof <= (row == '0) && (col == '0);
                pend_eol <= (col == COL_LAST);
`ifdef TEST_PATTERN_EN
                pend_pix <= tp_pix;
`endif
            end
            unique case (state)
                S_IDLE: begin
                    // the done cycle swallows a coincident start
                    if (start && !done) begin
                        state <= S_LAUNCH;
                        busy  <= 1'b1;
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
`ifdef TEST_PATTERN_EN
                        tp_mode <= tp_sel;
`endif
                    end
                end
                S_LAUNCH: state <= S_STREAM;
                S_STREAM: begin
                    if (issue) begin
                        addr <= addr + ADDR_W'(1);
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                            if (row == ROW_LAST) begin
                                state <= S_DRAIN;
                            end else if (HBLANK > 0) begin
                                state     <= S_HBLANK;
                                blank_cnt <= BLANK_INIT;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt == 8'd0) state <= S_STREAM;
                    else blank_cnt <= blank_cnt - 8'd1;
                end
                S_DRAIN: begin
                    if (occ_nxt == 2'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_pixel_streamer.sv
// tb_raster_pixel_streamer: 4x3 frames from random memory under random backpressure.
// Expected pixels come from a raster-order queue model; TEST_PATTERN_EN adds a pattern frame.
module tb_raster_pixel_streamer;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int NP = IW * IH;
    localparam int PW = 8;
    localparam int AW = $clog2(NP);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start0, ready0, rd0, val0, sof0, eol0, busy0, done0;
    logic [AW-1:0] addr0;
    logic [PW-1:0] rdata0, pix0;
    logic start5, rd5, val5, sof5, eol5, busy5, done5;
    logic [AW-1:0] addr5;
    logic [PW-1:0] rdata5, pix5;
`ifdef TEST_PATTERN_EN
    logic tp_sel;
`endif

    typedef struct packed {
        logic sof;
        logic eol;
        logic [PW-1:0] pix;
    } px_t;

    logic [PW-1:0] mem [NP];
    px_t exp_q[$];
    int total = 0;
    int bad = 0;
    int issued = 0;
    int xfer = 0;
    bit tp_on = 1'b0;
    bit prev_stall = 1'b0;
    px_t prev_px;

    raster_pixel_streamer #(.IMG_W(IW), .IMG_H(IH), .W(PW), .HBLANK(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .mem_rd_en(rd0), .mem_addr(addr0), .mem_rdata(rdata0),
        .out_valid(val0), .out_ready(ready0), .out_pixel(pix0),
        .out_sof(sof0), .out_eol(eol0), .busy(busy0), .done(done0)
    );

    raster_pixel_streamer #(.IMG_W(IW), .IMG_H(IH), .W(PW), .HBLANK(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5),
`ifdef TEST_PATTERN_EN
        .tp_sel(1'b0),
`endif
        .mem_rd_en(rd5), .mem_addr(addr5), .mem_rdata(rdata5),
        .out_valid(val5), .out_ready(1'b1), .out_pixel(pix5),
        .out_sof(sof5), .out_eol(eol5), .busy(busy5), .done(done5)
    );

    always @(posedge clk) begin
        if (rd0) rdata0 <= mem[addr0];
        if (rd5) rdata5 <= mem[addr5];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(val0), 1);
                chk("stall_data", 32'({sof0, eol0, pix0}), 32'(prev_px));
            end
`ifdef TEST_PATTERN_EN
            if (tp_on) chk("tp_no_read", 32'(rd0), 0);
`endif
            if (rd0) begin
                chk("addr", 32'(addr0), 32'(issued));
                chk("credit", 32'((issued - xfer - int'(val0 && ready0)) < 2), 1);
                issued++;
            end
            if (val0 && ready0) begin
                if (exp_q.size() == 0) chk("extra_pixel", 32'(exp_q.size()), 1);
                else chk("pixel", 32'({sof0, eol0, pix0}), 32'(exp_q.pop_front()));
                xfer++;
            end
            prev_stall = val0 && !ready0;
            prev_px = {sof0, eol0, pix0};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic load(input bit rnd, input bit tp);
        logic [PW-1:0] p;
        exp_q.delete();
        issued = 0;
        xfer = 0;
        tp_on = tp;
        for (int i = 0; i < NP; i++) begin
            mem[i] = rnd ? PW'($urandom) : PW'(i + 16);
            p = tp ? PW'(i % IW + i / IW) : mem[i];
            exp_q.push_back({i == 0, (i % IW) == IW - 1, p});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({rd0, val0, sof0, eol0, busy0, done0, addr0, pix0}), 0);
    endtask

    task automatic frame0(input int exp_done, input bit bp, input int mid_start, input bit abort);
        int first_rd;
        int first_val;
        int done_k;
        first_rd = -1;
        first_val = -1;
        done_k = -1;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        #1;
        chk("busy_after_start", 32'(busy0), 1);
        chk("no_rd_at_start", 32'(rd0), 0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (bp) ready0 = (k >= 6 && k < 26) ? 1'b0 : 1'($urandom_range(0, 1));
            start0 = (k == mid_start);
            #1;
            if (rd0 && first_rd < 0) first_rd = k;
            if (val0 && first_val < 0) first_val = k;
            if (abort && xfer == 6) begin
                rst_n = 1'b0;
                #1;
                chk_zero("reset_outputs");
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
            if (done0) begin
                done_k = k;
                break;
            end
        end
        if (!bp) begin
            chk("first_rd_cycle", 32'(first_rd), 1);
            chk("first_valid_cycle", 32'(first_val), 3);
            chk("done_cycle", 32'(done_k), 32'(exp_done));
        end else begin
            chk("done_seen", 32'(done_k > 0), 1);
        end
        chk("pixels_left", 32'(exp_q.size()), 0);
        chk("busy_at_done", 32'(busy0), 0);
    endtask

    task automatic frame5();
        int done_k;
        int gap;
        bit after_eol;
        done_k = -1;
        gap = 0;
        after_eol = 1'b0;
        @(posedge clk); #1 start5 = 1'b1;
        @(posedge clk); #1 start5 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #2;
            if (val5) begin
                if (after_eol) chk("hblank_gap", 32'(gap), 5);
                if (exp_q.size() == 0) chk("extra_pixel5", 32'(exp_q.size()), 1);
                else chk("pixel5", 32'({sof5, eol5, pix5}), 32'(exp_q.pop_front()));
                after_eol = eol5;
                gap = 0;
            end else if (after_eol) begin
                gap++;
            end
            if (done5) begin
                done_k = k;
                break;
            end
        end
        chk("done5_cycle", 32'(done_k), 25);
        chk("pixels_left5", 32'(exp_q.size()), 0);
    endtask

    initial begin
        start0 = 1'b0;
        start5 = 1'b0;
        ready0 = 1'b1;
`ifdef TEST_PATTERN_EN
        tp_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_zero("reset_state");
        chk("reset_busy5", 32'({busy5, val5, rd5}), 0);

        load(1'b0, 1'b0);
        frame0(15, 1'b0, 0, 1'b0);

        load(1'b1, 1'b0);
        frame0(0, 1'b1, 0, 1'b0);
        ready0 = 1'b1;

        load(1'b1, 1'b0);
        frame0(15, 1'b0, 5, 1'b0);
        load(1'b1, 1'b0);
        frame0(15, 1'b0, 0, 1'b0);

        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        #1;
        chk("coincident_start_busy", 32'({busy0, done0}), 0);
        @(posedge clk); #2;
        chk("coincident_start_rd", 32'({busy0, rd0}), 0);

        load(1'b1, 1'b0);
        frame0(15, 1'b0, 0, 1'b1);
        load(1'b1, 1'b0);
        frame0(15, 1'b0, 0, 1'b0);

        load(1'b1, 1'b0);
        frame5();

`ifdef TEST_PATTERN_EN
        load(1'b0, 1'b1);
        tp_sel = 1'b1;
        frame0(15, 1'b0, 0, 1'b0);
        tp_sel = 1'b0;
        tp_on = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
